// File: rtl/taillight_seq_if.sv
// Lamp-sequencer bus: turn/hazard requests toward the sequencer,
// lamp drive and status strobes back from it.
interface taillight_seq_if #(
    parameter int LAMPS = 3
);
    logic               left;
    logic               right;
    logic               hazard;
    logic [2*LAMPS-1:0] lights;
    logic               busy;
    logic               tick;

    modport master (
        output left,
        output right,
        output hazard,
        input  lights,
        input  busy,
        input  tick
    );

    modport slave (
        input  left,
        input  right,
        input  hazard,
        output lights,
        output busy,
        output tick
    );
endinterface

// File: rtl/taillight_seq.sv
// Sequential turn-signal / hazard controller: a free-running prescaler
// produces a step strobe, and a small FSM sweeps lamps outward per side.
module taillight_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    taillight_seq_if.slave bus
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(LAMPS + 1);
    localparam int NL = 2 * LAMPS;

    localparam logic [CW-1:0] COUNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(LAMPS);
    localparam logic [SW-1:0] STEP_ONE   = SW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_t;

    logic [CW-1:0] count_q, count_d;
    logic          tick_q,  tick_d;
    state_t        state_q, state_d;
    logic [SW-1:0] step_q,  step_d;
    logic [NL-1:0] lights_q, lights_d;
    logic          busy_q,  busy_d;

    logic          hazReq;
    logic          leftReq;
    logic          rightReq;
    state_t        decState;
    logic [SW-1:0] decStep;
    logic [LAMPS-1:0] sideMask;

    // Prescaler: tick is raised as the count wraps, so it lands one full
    // period after reset and stays high when TICK_DIV is 1.
    always_comb begin
        count_d = count_q + CW'(1);
        tick_d  = 1'b0;
        if (count_q == COUNT_LAST) begin
            count_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Both turn requests at once are treated as a hazard request.
    always_comb begin
        hazReq   = bus.hazard | (bus.left & bus.right);
        leftReq  = bus.left  & ~hazReq;
        rightReq = bus.right & ~hazReq;
    end

    always_comb begin
        decState = IDLE;
        decStep  = '0;
        if (hazReq) begin
            decState = HAZARD;
            decStep  = STEP_ONE;
        end else if (leftReq) begin
            decState = LEFT;
            decStep  = STEP_ONE;
        end else if (rightReq) begin
            decState = RIGHT;
            decStep  = STEP_ONE;
        end
    end

    // In HAZARD the step register doubles as the phase: 1 = all on, 0 = all off.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (step_q != '0) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    state_d = decState;
                    step_d  = decStep;
                end
            end
            LEFT, RIGHT: begin
                if (step_q > STEP_LAST) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (hazReq) begin
                    state_d = HAZARD;
                    step_d  = STEP_ONE;
                end else if (step_q == '0) begin
                    state_d = decState;
                    step_d  = decStep;
                end else if (step_q == STEP_LAST) begin
                    step_d  = '0;
                end else begin
                    step_d  = step_q + SW'(1);
                end
            end
            HAZARD: begin
                if (step_q == STEP_ONE) begin
                    step_d  = '0;
                end else if (step_q == '0) begin
                    state_d = decState;
                    step_d  = decStep;
                end else begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Lamp pattern is derived from the next state so it registers together with it.
    always_comb begin
        sideMask = '0;
        for (int i = 0; i < LAMPS; i++) begin
            sideMask[i] = (i < int'(step_d));
        end
        lights_d = '0;
        case (state_d)
            LEFT:    lights_d[LAMPS-1:0]  = sideMask;
            RIGHT:   lights_d[NL-1:LAMPS] = sideMask;
            HAZARD:  lights_d = (step_d == STEP_ONE) ? {NL{1'b1}} : {NL{1'b0}};
            default: lights_d = '0;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            lights_q <= '0;
            busy_q   <= 1'b0;
        end else if (tick_q) begin
            state_q  <= state_d;
            step_q   <= step_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.lights = lights_q;
    assign bus.busy   = busy_q;
    assign bus.tick   = tick_q;

endmodule

// File: doc/taillight_seq.md
TAILLIGHT_SEQ -- requirements
Module: taillight_seq

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 4, clock cycles per sequencing tick; legal range 1..65535.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 left  input  1  left-turn request, level, synchronous to clk.
REQ-006 right  input  1  right-turn request, level, synchronous to clk.
REQ-007 hazard  input  1  hazard request, level, synchronous to clk.
REQ-008 lights  output  2*LAMPS  registered lamp drive. Bits [LAMPS-1:0] are the left side, bit 0 innermost (LA). Bits [2*LAMPS-1:LAMPS] are the right side, bit LAMPS innermost (RA).
REQ-009 busy  output  1  registered; high whenever the state is not IDLE.
REQ-010 tick  output  1  registered one-cycle strobe marking a sequencing step.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 and wrap, free-running from reset.
REQ-012 tick SHALL be high for exactly one cycle per TICK_DIV cycles. With TICK_DIV=1, tick SHALL stay high continuously.
REQ-013 State and lights SHALL change only on a rising edge where tick is high. Inputs SHALL be sampled on that same edge. lights and busy SHALL show the new values in the following cycle.
REQ-014 States SHALL be IDLE, LEFT, RIGHT and HAZARD, plus a step counter 0..LAMPS.
REQ-015 Effective request decode: hazard=1, or left=1 and right=1, counts as a hazard request; otherwise left or right as given.
REQ-016 IDLE on tick:
- hazard request -> HAZARD with all lamps on;
- left -> LEFT step 1;
- right -> RIGHT step 1;
- no request -> remain in IDLE.
REQ-017 LEFT step k (1..LAMPS): lights[k-1:0]=1, all other bits 0.
REQ-018 RIGHT step k (1..LAMPS): lights[LAMPS+k-1:LAMPS]=1, all other bits 0.
REQ-019 From step k<LAMPS, the next tick SHALL go to step k+1. From step LAMPS, the next tick SHALL go to step 0 (all off, same direction).
REQ-020 On a tick at step 0, the next state SHALL be re-decoded exactly as in REQ-016, so a held request repeats the sweep.
REQ-021 Releasing left or right mid-sweep SHALL NOT abort it. The sweep SHALL complete through step 0, then the FSM re-decodes.
REQ-022 A hazard request seen on any tick while in LEFT or RIGHT SHALL override immediately: next state HAZARD, all lamps on.
REQ-023 In HAZARD, lights SHALL alternate all-on and all-off on each tick.
REQ-024 Leaving HAZARD SHALL occur only on a tick during the all-off phase when no hazard request is present. The FSM then re-decodes per REQ-016 on that same tick.
REQ-025 The opposite direction requested mid-sweep SHALL be ignored until the sweep reaches step 0.
REQ-026 Any unreachable state or step encoding SHALL return to IDLE with lights 0 on the next tick.

Reset
REQ-027 While reset_n=0, the block SHALL hold: state IDLE, step 0, prescaler 0, lights 0, busy 0, tick 0.
REQ-028 Reset assertion SHALL take effect asynchronously, including mid-sweep and mid-hazard.
REQ-029 After reset_n deasserts, the first tick SHALL occur TICK_DIV cycles later.

Verification (LAMPS=3, TICK_DIV=4 unless noted)
REQ-030 Hold left from reset -> lights steps 000001, 000011, 000111, 000000, 000001, ..., one step per 4 clk cycles; busy=1 throughout.
REQ-031 Pulse right for one tick period only -> lights 001000, 011000, 111000, 000000, then IDLE; busy falls after the off step.
REQ-032 Left held, hazard asserted at step 2 (000011) -> next tick 111111, then 000000, 111111. Release hazard during an all-on phase -> one more 000000 tick, then left sweep restarts at 000001.
REQ-033 left=1 and right=1 together from IDLE -> hazard pattern 111111 / 000000 alternating.
REQ-034 Assert reset_n=0 mid-clock at step 3 of a right sweep -> lights=0 and busy=0 immediately, without waiting for a clk edge. After release, IDLE until the first tick 4 cycles later.
REQ-035 LAMPS=8, TICK_DIV=1, left held -> lights advance every cycle: 0x0001, 0x0003, ..., 0x00FF, 0x0000; tick constantly high.
